gfifo_rd_packer: RTL and testbench
==================================

GFIFO_RD_PACKER -- requirements
Module: gfifo_rd_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named rd_clk and rst.
REQ-002 Parameter TIMEOUT SHALL default to 8 and set the maximum number of cycles to wait for rd_valid after a request.
REQ-003 Parameter LOW_FIRST SHALL default to 1; when 1, the first nibble read goes to out_data[3:0], otherwise to out_data[7:4].
REQ-004 rd_clk  in  1  read-domain clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 enable  in  1  permits new FIFO requests.
REQ-007 empty  in  1  FIFO empty flag, rd_clk domain.
REQ-008 rd_valid  in  1  FIFO read data valid.
REQ-009 rd_data  in  4  FIFO read data nibble.
REQ-010 rd_req_  out  1  active-low FIFO read request.
REQ-011 out_ready  in  1  downstream accepts a byte.
REQ-012 out_valid  out  1  byte available.
REQ-013 out_data  out  8  packed byte.
REQ-014 err_clr  in  1  clears timeout_err.
REQ-015 timeout_err  out  1  sticky flag: a requested nibble never arrived.
REQ-016 byte_cnt  out  8  count of bytes accepted downstream.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT and OUT.
REQ-018 IDLE: when enable=1 and empty=0, the block SHALL go to REQ on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 REQ: rd_req_ SHALL be driven low from a register for exactly one cycle, then the block SHALL go to WAIT.
REQ-020 Only one request SHALL be outstanding; rd_req_ SHALL be 1 in every state except REQ.
REQ-021 WAIT, on rd_valid=1 with nib_idx=0: store rd_data as the first nibble, set nib_idx=1, go to IDLE.
REQ-022 WAIT, on rd_valid=1 with nib_idx=1: store the second nibble, clear nib_idx, set out_valid=1 on the next edge, go to OUT.
REQ-023 WAIT timeout: if rd_valid has not arrived after TIMEOUT cycles, the block SHALL set timeout_err, discard any partial nibble (nib_idx=0) and go to IDLE.
REQ-024 rd_valid outside WAIT SHALL be ignored, with no data capture and no state change.
REQ-025 OUT: out_data and out_valid SHALL hold stable until out_ready=1.
REQ-026 A handshake (out_valid & out_ready) SHALL clear out_valid, increment byte_cnt modulo 256 (255->0) and go to IDLE.
REQ-027 enable is sampled only in IDLE; deasserting it mid-byte SHALL NOT abort REQ, WAIT or OUT.
REQ-028 When enable drops with nib_idx=1, the partial nibble SHALL be retained until a later request completes the byte.
REQ-029 err_clr SHALL clear timeout_err on the next edge; a timeout in the same cycle SHALL take priority and leave the flag set.
REQ-030 Minimum byte latency: with one-cycle FIFO read latency and out_ready=1, a byte SHALL take 6 cycles (IDLE, REQ, WAIT, IDLE, REQ, WAIT) before out_valid rises.

Reset
REQ-031 On rst=1, the block SHALL asynchronously force: state=IDLE, rd_req_=1, out_valid=0, out_data=0, nib_idx=0, timeout counter=0, timeout_err=0, byte_cnt=0.
REQ-032 Reset asserted mid-operation SHALL abandon any outstanding request and partial byte; FIFO data already popped is lost by design.
REQ-033 Reset release SHALL be synchronous to rd_clk; the first request SHALL come no earlier than the second edge after release.

Structure
REQ-034 Shared package gfifo_pkg SHALL hold: the state enum type, NIB_W=4, BYTE_W=8 and the default TIMEOUT.
REQ-035 The wait counter SHALL be a sub-module, gfifo_rd_timer, with load, tick and expire ports, counter width $clog2(TIMEOUT+1).
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Nibbles 0x3 then 0xA, 1-cycle rd_valid latency, out_ready=1 -> out_data=0xA3, out_valid for 1 cycle, byte_cnt=1.
REQ-038 LOW_FIRST=0, same stimulus -> out_data=0x3A.
REQ-039 out_ready=0 for 5 cycles -> out_data=0xA3 held, no rd_req_ pulses; after ready, byte_cnt increments once.
REQ-040 rd_valid withheld after a request -> timeout_err=1 exactly TIMEOUT=8 cycles after WAIT entry, nib_idx=0; err_clr pulse -> timeout_err=0.
REQ-041 256 bytes streamed back-to-back -> byte_cnt wraps to 0, no lost or duplicated nibbles.
REQ-042 rst pulsed in WAIT with nib_idx=1 -> all outputs at reset values, rd_req_=1; next byte packed from fresh nibbles.

Source files
------------

// File: rtl/gfifo_pkg.sv
// Shared types and sizes for the nibble-to-byte FIFO read packer.
package gfifo_pkg;
  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 8;
  localparam int TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;
endpackage

// File: rtl/gfifo_rd_timer.sv
// Wait-for-data counter: cleared on load, counts ticks, flags the last
// allowed cycle so the caller can bail out on the following edge.
module gfifo_rd_timer
  import gfifo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic rd_clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);
  logic [CW-1:0] cnt;

  // Expire on the TIMEOUT-th ticking cycle since load.
  assign expire = tick && (cnt == CW'(TIMEOUT - 1));

  // Count waiting cycles; holds once expired until reloaded.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= '0;
    else if (tick && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/gfifo_rd_packer.sv
// Pops nibbles from a FIFO one request at a time and packs pairs into
// bytes for a valid/ready consumer. Missing read data raises a sticky error.
module gfifo_rd_packer
  import gfifo_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic              rd_valid,
  input  logic [NIB_W-1:0]  rd_data,
  output logic              rd_req_,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic [7:0]        byte_cnt
);
  state_e           state;
  logic             nib_idx;
  logic             armed;
  logic [NIB_W-1:0] first_nib;
  logic             tmr_load, tmr_tick, tmr_expire;

  // Timer restarts while the request is out; arriving data beats a timeout.
  assign tmr_load = (state == REQ);
  assign tmr_tick = (state == WAIT) && !rd_valid;

  gfifo_rd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .rd_clk (rd_clk),
    .rst    (rst),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expire (tmr_expire)
  );

  // Request/capture/pack FSM; every output is a register written here.
  // armed delays the first request by one edge after reset release.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_req_     <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      nib_idx     <= 1'b0;
      first_nib   <= '0;
      timeout_err <= 1'b0;
      byte_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: if (armed && enable && !empty) begin
          rd_req_ <= 1'b0;
          state   <= REQ;
        end
        REQ: begin
          rd_req_ <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (rd_valid) begin
            if (!nib_idx) begin
              first_nib <= rd_data;
              nib_idx   <= 1'b1;
              state     <= IDLE;
            end else begin
              nib_idx   <= 1'b0;
              out_data  <= LOW_FIRST ? {rd_data, first_nib} : {first_nib, rd_data};
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end else if (tmr_expire) begin
            // Later assignment overrides a same-cycle err_clr.
            timeout_err <= 1'b1;
            nib_idx     <= 1'b0;
            state       <= IDLE;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          byte_cnt  <= byte_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gfifo_rd_packer.sv
// Directed bench for gfifo_rd_packer: a FIFO model with one-cycle read
// latency, two instances (low-first and high-first packing).
module tb_gfifo_rd_packer;
  import gfifo_pkg::*;

  logic       rd_clk = 1'b0, rst = 1'b1, enable = 1'b0, empty = 1'b1;
  logic       rd_valid = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
  logic [3:0] rd_data = 4'h0;
  logic       rd_req_, out_valid, timeout_err;
  logic [7:0] out_data, byte_cnt;
  logic       rd_req_h, out_valid_h, timeout_err_h;
  logic [7:0] out_data_h, byte_cnt_h;

  int         n_chk = 0, n_pass = 0;
  logic [3:0] nibq[$];
  logic       pend = 1'b0, withhold = 1'b0, spur = 1'b0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 rd_clk = ~rd_clk;

  gfifo_rd_packer #(.TIMEOUT(8), .LOW_FIRST(1'b1)) dut (
    .rd_clk(rd_clk), .rst(rst), .enable(enable), .empty(empty),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_req_(rd_req_),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .err_clr(err_clr), .timeout_err(timeout_err), .byte_cnt(byte_cnt));

  gfifo_rd_packer #(.TIMEOUT(8), .LOW_FIRST(1'b0)) dut_h (
    .rd_clk(rd_clk), .rst(rst), .enable(enable), .empty(empty),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_req_(rd_req_h),
    .out_ready(out_ready), .out_valid(out_valid_h), .out_data(out_data_h),
    .err_clr(err_clr), .timeout_err(timeout_err_h), .byte_cnt(byte_cnt_h));

  // FIFO model: a request seen in one cycle returns data in the next.
  always @(negedge rd_clk) begin
    if (spur) begin
      rd_valid = 1'b1;
      rd_data  = 4'hF;
    end else if (pend && nibq.size() > 0) begin
      rd_valid = 1'b1;
      rd_data  = nibq.pop_front();
    end else begin
      rd_valid = 1'b0;
    end
    pend  = !rd_req_ && !withhold;
    empty = (nibq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge rd_clk);
    #1;
  endtask

  // Wait for out_valid; lat = cycles from first rd_req_ low to out_valid.
  task automatic wait_out(input string tag, output int lat);
    int  first;
    bit  seen;
    first = -1;
    lat   = -1;
    seen  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!rd_req_ && first < 0) first = i;
      if (out_valid) begin
        seen = 1'b1;
        lat  = i - first;
        break;
      end
      step();
    end
    chk({tag, "_done"}, seen, 1);
    if (out_ready && seen) exp_cnt++;
  endtask

  task automatic wait_req(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!rd_req_) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk(tag, got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         lat, nb, err;
    logic [7:0] expb;

    // Reset values
    enable = 1'b1;
    step(); step();
    chk("rst_req",   rd_req_,     1);
    chk("rst_valid", out_valid,   0);
    chk("rst_data",  out_data,    0);
    chk("rst_err",   timeout_err, 0);
    chk("rst_cnt",   byte_cnt,    0);

    // First byte 0x3 then 0xA; no request on the first edge after release
    nibq.push_back(4'h3); nibq.push_back(4'hA);
    step();
    rst = 1'b0;
    step();
    chk("no_early_req", rd_req_, 1);
    step();
    chk("first_req", rd_req_, 0);
    wait_out("b_a3", lat);
    chk("b_a3_data", out_data, 8'hA3);
    chk("b_3a_data_hf", {out_valid_h, out_data_h}, {1'b1, 8'h3A});
    step();
    chk("b_a3_pulse", out_valid, 0);
    chk("b_a3_cnt", byte_cnt, exp_cnt);

    // Minimum latency from request to out_valid
    nibq.push_back(4'h5); nibq.push_back(4'hC);
    wait_out("b_c5", lat);
    chk("lat", lat, 5);
    chk("b_c5_data", out_data, 8'hC5);
    step();
    chk("b_c5_cnt", byte_cnt, exp_cnt);

    // Back-pressure: byte held, no requests while waiting for ready
    out_ready = 1'b0;
    nibq.push_back(4'h3); nibq.push_back(4'hA);
    nibq.push_back(4'h1); nibq.push_back(4'h2);
    wait_out("hold", lat);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_stable", {out_valid, rd_req_, out_data}, {1'b1, 1'b1, 8'hA3});
    end
    chk("hold_cnt", byte_cnt, exp_cnt);
    out_ready = 1'b1;
    exp_cnt++;
    step();
    chk("hold_release", {out_valid, byte_cnt}, {1'b0, exp_cnt});
    wait_out("b_21", lat);
    chk("b_21_data", out_data, 8'h21);
    step();

    // Timeout with a partial nibble pending
    nibq.push_back(4'h7);
    repeat (10) step();
    withhold = 1'b1;
    nibq.push_back(4'h9);
    wait_req("to_req");
    repeat (8) step();
    chk("to_early", timeout_err, 0);
    step();
    chk("to_set", timeout_err, 1);
    enable   = 1'b0;
    withhold = 1'b0;

    // Stray rd_valid outside WAIT changes nothing
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    chk("err_sticky", {timeout_err, out_valid, rd_req_}, {1'b1, 1'b0, 1'b1});
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);

    // Partial 0x7 was dropped: next byte is 0x9 then 0xB
    nibq.push_back(4'hB);
    enable = 1'b1;
    wait_out("b_b9", lat);
    chk("b_b9_data", out_data, 8'hB9);
    step();

    // Reset in WAIT with one nibble held
    nibq.push_back(4'h4);
    repeat (8) step();
    withhold = 1'b1;
    nibq.push_back(4'h6);
    wait_req("mid_req");
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst", {rd_req_, out_valid, out_data, timeout_err, byte_cnt},
        {1'b1, 1'b0, 8'h00, 1'b0, 8'h00});
    step();
    rst      = 1'b0;
    withhold = 1'b0;
    nibq.delete();
    exp_cnt  = 8'd0;
    nibq.push_back(4'h1); nibq.push_back(4'h2);
    wait_out("post_rst", lat);
    chk("post_rst_data", out_data, 8'h21);
    step();
    chk("post_rst_cnt", byte_cnt, exp_cnt);

    // 256 bytes back-to-back; counter wraps through zero
    for (int b = 0; b < 256; b++) begin
      expb = 8'(b);
      nibq.push_back(expb[3:0]);
      nibq.push_back(expb[7:4]);
    end
    nb   = 0;
    err  = 0;
    expb = 8'd0;
    for (int i = 0; i < 256 * 8 + 50; i++) begin
      if (out_valid) begin
        if (out_data !== expb) err++;
        if (byte_cnt !== exp_cnt) err++;
        exp_cnt++;
        expb++;
        nb++;
        if (nb == 256) break;
      end
      step();
    end
    chk("stream_bytes", nb, 256);
    chk("stream_err", err, 0);
    step();
    chk("wrap_cnt", byte_cnt, exp_cnt);
    chk("stream_q", nibq.size(), 0);
    chk("hf_state", {timeout_err_h, rd_req_h, byte_cnt_h}, {1'b0, 1'b1, exp_cnt});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
